// File: rtl/jesd_tx_pkg.sv
// ---------------------------------------------------------------------------
// jesd_tx_pkg
// Shared definitions for the JESD204B TX link-layer sequencer:
//   - link_state_e : CGS / ILA_WAIT / ILA / DATA state encoding
//   - K28_x        : 8b10b control-character octets (HGFEDCBA)
//   - RESYNC_*     : terms of the SYNC~ re-sync threshold T = 5*F + 9
//   - resync_threshold() : T computed from the F-1 encoded frame size
// ---------------------------------------------------------------------------
package jesd_tx_pkg;

    typedef enum logic [1:0] {
        ST_CGS      = 2'd0,
        ST_ILA_WAIT = 2'd1,
        ST_ILA      = 2'd2,
        ST_DATA     = 2'd3
    } link_state_e;

    localparam logic [7:0] K28_0 = 8'h1C;
    localparam logic [7:0] K28_3 = 8'h7C;
    localparam logic [7:0] K28_4 = 8'h9C;
    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K28_7 = 8'hFC;

    localparam int RESYNC_MULT = 5;
    localparam int RESYNC_OFFS = 9;

    // f_m1 is F-1; the largest result (F=256) is 1289, well inside 12 bits.
    function automatic logic [11:0] resync_threshold(input logic [7:0] f_m1);
        return 12'(RESYNC_MULT) * ({4'd0, f_m1} + 12'd1) + 12'(RESYNC_OFFS);
    endfunction

endpackage

// File: rtl/tx_link_ctrl_sync_ff.sv
// ---------------------------------------------------------------------------
// sync_ff
// Multi-flop synchroniser for a single asynchronous level.
// Ports:
//   clk   in  destination clock
//   rst_n in  asynchronous active-low reset; all flops reset to 1'b0
//   i_d   in  asynchronous input
//   o_q   out synchronised output, STAGES clocks behind i_d
// ---------------------------------------------------------------------------
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/tx_link_ctrl.sv
// ---------------------------------------------------------------------------
// tx_link_ctrl
// JESD204B Subclass 2 TX link-layer sequencer. Keeps a free-running LMFC,
// synchronises and monitors SYNC~, walks the link through CGS -> ILA_WAIT ->
// ILA -> DATA, and muxes K28.5 / ILA octets / user octets onto one
// registered octet stream.
//
// Optional feature: define TX_LINK_ERR_CNT_EN to implement the SYNC~
// error-report counter; otherwise o_err_cnt is tied to zero.
//
// Ports:
//   clk, rst_n      character clock, asynchronous active-low reset
//   i_sync_n        asynchronous SYNC~ (active low)
//   i_F, i_K        octets/frame and frames/multiframe, both encoded minus 1
//   i_ila_data/k    octet and K flag from the ILA generator
//   i_ila_seq_end   ILA last-octet pulse
//   i_data          user/transport octet
//   o_ila_start     one-cycle start pulse to the ILA generator
//   o_no_frame      frame index captured on the SYNC~ de-assertion
//   o_data/o_k      registered output octet and control flag
//   o_data_ready    high while i_data is consumed (DATA state)
//   o_state         current link state (debug)
//   o_err_cnt       saturating count of SYNC~ error reports
// ---------------------------------------------------------------------------
module tx_link_ctrl
    import jesd_tx_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_sync_n,
    input  logic [7:0]           i_F,
    input  logic [4:0]           i_K,
    input  logic [7:0]           i_ila_data,
    input  logic                 i_ila_k,
    input  logic                 i_ila_seq_end,
    input  logic [7:0]           i_data,
    output logic                 o_ila_start,
    output logic [4:0]           o_no_frame,
    output logic [7:0]           o_data,
    output logic                 o_k,
    output logic                 o_data_ready,
    output logic [1:0]           o_state,
    output logic [ERR_CNT_W-1:0] o_err_cnt
);

    logic        w_sync_s;
    logic        r_sync_d;
    logic        w_sync_rise;

    logic [7:0]  r_oct;
    logic [4:0]  r_frm;
    logic [9:0]  r_mfo;
    logic [10:0] r_mfl;
    logic        w_oct_wrap;
    logic        w_frm_wrap;
    logic        w_start_slot;

    logic [11:0] r_low_cnt;
    logic [11:0] w_thr;
    logic        w_resync;

    link_state_e r_state;
    logic        r_ila_start;
    logic [4:0]  r_no_frame;
    logic [7:0]  r_data;
    logic        r_k;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (i_sync_n),
        .o_q   (w_sync_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_d <= 1'b0;
        end else begin
            r_sync_d <= w_sync_s;
        end
    end

    assign w_sync_rise = w_sync_s & ~r_sync_d;

    // LMFC: octet and frame counters plus a direct multiframe-octet index.
    // Wrapping on >= keeps the counters sane if F/K shrink while in CGS.
    assign w_oct_wrap = (r_oct >= i_F);
    assign w_frm_wrap = w_oct_wrap && (r_frm >= i_K);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_oct <= '0;
            r_frm <= '0;
            r_mfo <= '0;
            r_mfl <= '0;
        end else begin
            r_mfl <= ({6'd0, i_K} + 11'd1) * ({3'd0, i_F} + 11'd1);
            r_oct <= w_oct_wrap ? 8'd0 : r_oct + 8'd1;
            if (w_oct_wrap) begin
                r_frm <= w_frm_wrap ? 5'd0 : r_frm + 5'd1;
            end
            r_mfo <= w_frm_wrap ? 10'd0 : r_mfo + 10'd1;
        end
    end

    // o_ila_start is registered, so it is launched one octet early to be
    // visible on the mfo == MFL-2 cycle; the generator's 2-cycle latency then
    // lands its first K28.0 on mfo == 0.
    assign w_start_slot = ({1'b0, r_mfo} == (r_mfl - 11'd3));

    // SYNC~ low-duration counter, saturating; clears on the cycle after
    // sync_s returns high so the rising-edge cycle still sees the full count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_low_cnt <= '0;
        end else if (w_sync_s) begin
            r_low_cnt <= '0;
        end else if (r_low_cnt != 12'hFFF) begin
            r_low_cnt <= r_low_cnt + 12'd1;
        end
    end

    assign w_thr    = resync_threshold(i_F);
    assign w_resync = (r_low_cnt >= w_thr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_CGS;
            r_ila_start <= 1'b0;
            r_no_frame  <= '0;
            r_data      <= K28_5;
            r_k         <= 1'b1;
        end else begin
            r_data      <= K28_5;
            r_k         <= 1'b1;
            r_ila_start <= 1'b0;
            case (r_state)
                ST_CGS: begin
                    if (w_sync_rise) begin
                        r_no_frame <= r_frm;
                        r_state    <= ST_ILA_WAIT;
                    end
                end
                ST_ILA_WAIT: begin
                    if (!w_sync_s) begin
                        r_state <= ST_CGS;
                    end else if (r_ila_start) begin
                        r_state <= ST_ILA;
                    end else if (w_start_slot) begin
                        r_ila_start <= 1'b1;
                    end
                end
                ST_ILA: begin
                    // Re-sync outranks a coincident end-of-ILA.
                    if (w_resync) begin
                        r_state <= ST_CGS;
                    end else begin
                        r_data <= i_ila_data;
                        r_k    <= i_ila_k;
                        if (i_ila_seq_end) begin
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_resync) begin
                        r_state <= ST_CGS;
                    end else begin
                        r_data <= i_data;
                        r_k    <= 1'b0;
                    end
                end
                default: r_state <= ST_CGS;
            endcase
        end
    end

`ifdef TX_LINK_ERR_CNT_EN
    logic                 w_short_low;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    // A SYNC~ low pulse that ends before the threshold is an error report.
    assign w_short_low = w_sync_rise && (r_low_cnt != 12'd0) && !w_resync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if ((r_state == ST_ILA || r_state == ST_DATA) && w_short_low
                     && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign o_err_cnt = r_err_cnt;
`else
    assign o_err_cnt = '0;
`endif

    assign o_ila_start  = r_ila_start;
    assign o_no_frame   = r_no_frame;
    assign o_data       = r_data;
    assign o_k          = r_k;
    assign o_state      = r_state;
    assign o_data_ready = (r_state == ST_DATA);

endmodule

// File: tb/tb_tx_link_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tx_link_ctrl
// Randomised bench for tx_link_ctrl. A driver issues SYNC~ pulses, user and
// ILA-generator octets each cycle, steps a behavioural link model and pushes
// the expected output vector; a monitor pops and compares every cycle.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tx_link_ctrl;

    localparam int SYNC_STAGES = 2;
    localparam int ERR_CNT_W   = 8;
    localparam int EW          = 26;
    localparam int N_ITER      = 10;
    localparam int N_CYC       = 900;
`ifdef TX_LINK_ERR_CNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 i_sync_n = 1'b0;
    logic [7:0]           i_F = 8'd1;
    logic [4:0]           i_K = 5'd31;
    logic [7:0]           i_ila_data = 8'd0;
    logic                 i_ila_k = 1'b0;
    logic                 i_ila_seq_end = 1'b0;
    logic [7:0]           i_data = 8'd0;
    logic                 o_ila_start;
    logic [4:0]           o_no_frame;
    logic [7:0]           o_data;
    logic                 o_k;
    logic                 o_data_ready;
    logic [1:0]           o_state;
    logic [ERR_CNT_W-1:0] o_err_cnt;

    tx_link_ctrl #(
        .SYNC_STAGES (SYNC_STAGES),
        .ERR_CNT_W   (ERR_CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_sync_n      (i_sync_n),
        .i_F           (i_F),
        .i_K           (i_K),
        .i_ila_data    (i_ila_data),
        .i_ila_k       (i_ila_k),
        .i_ila_seq_end (i_ila_seq_end),
        .i_data        (i_data),
        .o_ila_start   (o_ila_start),
        .o_no_frame    (o_no_frame),
        .o_data        (o_data),
        .o_k           (o_k),
        .o_data_ready  (o_data_ready),
        .o_state       (o_state),
        .o_err_cnt     (o_err_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    // Link phase numbers are the documented debug codes:
    // 0 CGS, 1 waiting for ILA slot, 2 ILA, 3 DATA.
    int         m_cyc;
    bit         m_sync_pipe[$];
    bit         m_prev_s;
    int         m_low_run;
    int         m_phase;
    bit         m_start;
    int         m_no_frame;
    logic [7:0] m_data;
    bit         m_k;
    int         m_err;
    int         m_F, m_K, m_mfl, m_thr;
    int         cov_data, cov_start, cov_err;

    // stimulus state
    int gen_idx = 0;
    int gen_len = 0;
    int low_left, high_left;

    function automatic logic [EW-1:0] dut_vec();
        return {o_state, o_data, o_k, o_ila_start, o_no_frame, o_data_ready, o_err_cnt};
    endfunction

    function automatic logic [EW-1:0] model_vec();
        return {2'(m_phase), m_data, m_k, m_start, 5'(m_no_frame), (m_phase == 3), 8'(m_err)};
    endfunction

    task automatic model_reset();
        m_cyc = 0;
        m_sync_pipe.delete();
        for (int i = 0; i < SYNC_STAGES; i++) m_sync_pipe.push_back(1'b0);
        m_prev_s   = 1'b0;
        m_low_run  = 0;
        m_phase    = 0;
        m_start    = 1'b0;
        m_no_frame = 0;
        m_data     = 8'hBC;
        m_k        = 1'b1;
        m_err      = 0;
        m_F        = int'(i_F) + 1;
        m_K        = int'(i_K) + 1;
        m_mfl      = m_F * m_K;
        m_thr      = 5 * m_F + 9;
    endtask

    // One character clock of the link, evaluated from the current inputs.
    task automatic model_step();
        bit         s, rise, resync, nk, nstart;
        int         mfo, nphase;
        logic [7:0] nd;
        s      = m_sync_pipe[0];
        rise   = s && !m_prev_s;
        mfo    = m_cyc % m_mfl;
        resync = (m_low_run >= m_thr);
        nphase = m_phase;
        nd     = 8'hBC;
        nk     = 1'b1;
        nstart = 1'b0;
        case (m_phase)
            0: if (rise) begin
                   m_no_frame = mfo / m_F;
                   nphase = 1;
               end
            1: if (!s) nphase = 0;
               else if (m_start) nphase = 2;
               else if (mfo == m_mfl - 3) nstart = 1'b1;
            2: if (resync) nphase = 0;
               else begin
                   nd = i_ila_data;
                   nk = i_ila_k;
                   if (i_ila_seq_end) nphase = 3;
               end
            default: if (resync) nphase = 0;
               else begin
                   nd = i_data;
                   nk = 1'b0;
               end
        endcase
        if (ERR_EN && m_phase >= 2 && rise && m_low_run >= 1 && m_low_run < m_thr && m_err < 255) begin
            m_err++;
            cov_err++;
        end
        m_low_run = s ? 0 : ((m_low_run < 4095) ? m_low_run + 1 : m_low_run);
        m_prev_s  = s;
        void'(m_sync_pipe.pop_front());
        m_sync_pipe.push_back(i_sync_n);
        m_cyc++;
        m_phase = nphase;
        m_data  = nd;
        m_k     = nk;
        m_start = nstart;
        if (m_phase == 3) cov_data++;
        if (m_start) cov_start++;
    endtask

    // ---------------- driver ----------------
    task automatic drive_cycle();
        int plen, sel;
        // ILA generator: idle, then K28.0 two cycles after the start pulse.
        if (gen_idx >= 0 && gen_idx < gen_len) begin
            i_ila_data    = (gen_idx == 0) ? 8'h1C : ((gen_idx == gen_len - 1) ? 8'h7C : 8'($urandom));
            i_ila_k       = (gen_idx == 0) || (gen_idx == gen_len - 1);
            i_ila_seq_end = (gen_idx == gen_len - 1);
        end else begin
            i_ila_data    = 8'($urandom);
            i_ila_k       = 1'($urandom);
            i_ila_seq_end = 1'b0;
        end
        if (gen_idx < gen_len) gen_idx++;
        if (m_start) begin
            gen_idx = -1;
            gen_len = $urandom_range(3, 40);
        end
        // SYNC~: random low pulses, short, near-threshold and long.
        if (i_sync_n == 1'b0) begin
            if (low_left > 0) low_left--;
            else begin
                i_sync_n  = 1'b1;
                high_left = $urandom_range(3, 12);
            end
        end else if (high_left > 0) begin
            high_left--;
        end else if ($urandom_range(0, 149) == 0) begin
            sel = $urandom_range(0, 9);
            if (sel < 5)      plen = $urandom_range(1, m_thr - 1);
            else if (sel < 8) plen = $urandom_range(m_thr - 2, m_thr + 2);
            else              plen = $urandom_range(m_thr + 1, m_thr + 30);
            i_sync_n = 1'b0;
            low_left = plen - 1;
        end
        i_data = 8'($urandom);
        model_step();
        exp_q.push_back(model_vec());
    endtask

    task automatic check_reset(input string name);
        logic [EW-1:0] rv;
        rv = {2'd0, 8'hBC, 1'b1, 1'b0, 5'd0, 1'b0, 8'd0};
        n_tests++;
        if (dut_vec() !== rv) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, dut_vec(), rv);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [EW-1:0] e, g;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = dut_vec();
                n_tests++;
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL stream t=%0t: got st=%0d d=%h k=%b start=%b nf=%0d rdy=%b err=%0d required st=%0d d=%h k=%b start=%b nf=%0d rdy=%b err=%0d",
                             $time, g[25:24], g[23:16], g[15], g[14], g[13:9], g[8], g[7:0],
                             e[25:24], e[23:16], e[15], e[14], e[13:9], e[8], e[7:0]);
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int f, k, kmin;
        cov_data  = 0;
        cov_start = 0;
        cov_err   = 0;
        @(negedge clk);
        for (int it = 0; it < N_ITER; it++) begin
            // Reset lands mid-cycle in whatever phase the last run left.
            rst_n    = 1'b0;
            i_sync_n = 1'b0;
            exp_q.delete();
            #1;
            check_reset("reset_async");
            if (it == 0) begin
                i_F = 8'd1;
                i_K = 5'd31;
            end else begin
                f    = $urandom_range(1, 4);
                kmin = (17 + f - 1) / f;
                k    = $urandom_range(kmin, 32);
                i_F  = 8'(f - 1);
                i_K  = 5'(k - 1);
            end
            repeat (3) @(negedge clk);
            check_reset("reset_held");
            rst_n = 1'b1;
            model_reset();
            gen_idx   = 0;
            gen_len   = 0;
            low_left  = $urandom_range(4, 2 * m_mfl);
            high_left = 0;
            for (int c = 0; c < N_CYC; c++) begin
                drive_cycle();
                @(negedge clk);
            end
        end
        n_tests++;
        if (cov_data == 0 || cov_start == 0 || (ERR_EN && cov_err == 0)) begin
            n_fail++;
            $display("FAIL coverage: data=%0d start=%0d err=%0d required nonzero", cov_data, cov_start, cov_err);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_link_ctrl.md
Name: tx_link_ctrl

Overview:
JESD204B TX link-layer sequencer for Subclass 2 operation.
- Keeps a local frame/LMFC counter, synchronises and monitors SYNC~, and walks the link through CGS, ILA and data phases.
- Supplies the ILA generator with its start pulse and the frame position at SYNC~ de-assertion.
- Muxes K28.5, ILA octets or user octets onto one registered octet stream that feeds the scrambler/8b10b stage.

Parameters:
- SYNC_STAGES, 2, depth of the SYNC~ synchroniser flops (≥2).
- ERR_CNT_W, 8, width of the error-report counter.

Ports:
- clk  in  1  character clock.
- rst_n  in  1  reset (see Behaviour).
- i_sync_n  in  1  asynchronous SYNC~ from the receiver, active low.
- i_F  in  8  octets per frame, encoded F−1.
- i_K  in  5  frames per multiframe, encoded K−1; (K·F) is 17..1024 by configuration rule.
- i_ila_data  in  8  octet from the ILA generator.
- i_ila_k  in  1  K flag from the ILA generator.
- i_ila_seq_end  in  1  ILA last-octet pulse.
- i_data  in  8  user/transport octet.
- o_ila_start  out  1  one-cycle start pulse to the ILA generator.
- o_no_frame  out  5  frame index captured at SYNC~ de-assertion.
- o_data  out  8  output octet, HGFEDCBA.
- o_k  out  1  control-character flag for o_data.
- o_data_ready  out  1  high while i_data is being consumed.
- o_state  out  2  current state, for debug.
- o_err_cnt  out  ERR_CNT_W  count of error-report pulses (feature-dependent).

Behaviour:
- Reset: rst_n asynchronous, active-low; clock clk. During and after reset:
  - o_data=8'hBC (K28.5), o_k=1, o_ila_start=0, o_no_frame=0, o_data_ready=0, o_state=CGS, o_err_cnt=0.
  - Counters and synchroniser flops reset to 0; synchroniser resets to the asserted level.
- LMFC counters: octet counter 0..i_F and frame counter 0..i_K, free-running from reset in every state.
  - Octet counter wraps after i_F; the frame counter increments on that wrap and itself wraps after i_K.
  - Multiframe octet index mfo = frame·(F)+octet, 10 bits. Multiframe length MFL=(i_K+1)(i_F+1), registered.
  - Configuration inputs are static outside CGS; a change while not in CGS is undefined.
- sync_s = i_sync_n after SYNC_STAGES flops.
- States:
  - CGS (0):
    - Output K28.5, k=1.
    - On a sync_s rising edge, capture the current frame counter into o_no_frame and go to ILA_WAIT.
  - ILA_WAIT (1):
    - Output K28.5, k=1.
    - Pulse o_ila_start for one cycle when mfo == MFL−2, then go to ILA next cycle.
    - Timing: the generator has 2-cycle start-to-K28.0 latency, so its first K28.0 arrives on the mfo==0 cycle.
    - If sync_s falls while in ILA_WAIT, return to CGS.
  - ILA (2):
    - o_data/o_k ← i_ila_data/i_ila_k, registered, 1-cycle latency.
    - When i_ila_seq_end==1, that octet is still forwarded and the state goes to DATA on the next cycle.
  - DATA (3):
    - o_data ← i_data, o_k=0, 1-cycle latency.
    - o_data_ready=1, combinational on the state.
- SYNC~ monitor in ILA and DATA:
  - Low-duration counter: 12-bit, saturating, counts cycles while sync_s==0, clears when sync_s==1.
  - Threshold T = 5·(F)+9 octets.
  - If the counter reaches T: go to CGS on the next cycle (re-sync request), whatever octet is in flight.
  - If sync_s rises with count in 1..T−1: error report. Increment o_err_cnt (saturating at all-ones) and keep the state.
- Simultaneous events:
  - If a re-sync threshold and i_ila_seq_end occur on the same cycle, re-sync wins (go to CGS).
  - o_ila_start is never asserted outside ILA_WAIT.
- Reset mid-operation: immediate return to the reset values above; the LMFC phase restarts at 0.

Optional Feature:
- Macro TX_LINK_ERR_CNT_EN.
- Defined: the error-report counter is implemented as specified.
- Undefined: o_err_cnt is tied to 0 and no error logic is synthesised. Short SYNC~ pulses are still ignored; re-sync is unaffected.

Decomposition:
- Package jesd_tx_pkg holds:
  - State encodings CGS/ILA_WAIT/ILA/DATA.
  - K-character constants K28_0, K28_3, K28_4, K28_5, K28_7.
  - Re-sync threshold constants 5 and 9.
- One sub-module, sync_ff: parameterised SYNC_STAGES flop synchroniser with reset value 1'b0.

Test Plan:
1. Reset release with i_sync_n=0, i_F=1 (F=2) → o_data=8'hBC, o_k=1 every cycle; o_state=0.
2. i_K=31, i_F=1 (MFL=64); raise i_sync_n when frame counter=3 → o_no_frame=3. o_ila_start pulses exactly once, on the cycle with mfo=62; i_ila_data then appears on o_data one cycle later.
3. In ILA, pulse i_ila_seq_end with i_ila_data=8'h7C → o_data=8'h7C next cycle. The following cycle o_state=3, o_data_ready=1, and o_data tracks i_data (8'hA5 → 8'hA5) with 1-cycle latency.
4. In DATA with F=2, drop i_sync_n for 25 cycles (>T=19) → return to CGS after count 19; o_data=8'hBC, o_k=1; a new ILA follows the next SYNC~ rise.
5. With TX_LINK_ERR_CNT_EN, in DATA drop i_sync_n for 4 cycles → o_err_cnt 0→1, o_state stays 3. Without the macro, o_err_cnt stays 0.
6. Assert rst_n=0 mid-ILA → all outputs at reset values in the same cycle; ILA restarts only after a new SYNC~ rising edge.
